alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_opdecode.sv | 56 +++++
 rtl/alu_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, enable bit indices,
// the one-hot enable type and the sequencer state encoding.
package alu_pkg;

  localparam int unsigned EN_W  = 15;
  localparam int unsigned CNT_W = 4;

  typedef logic [EN_W-1:0] en_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Enable bit positions
  localparam int unsigned EN_ADD  = 0;
  localparam int unsigned EN_SUB  = 1;
  localparam int unsigned EN_MUL  = 2;
  localparam int unsigned EN_DIV  = 3;
  localparam int unsigned EN_MOD  = 4;
  localparam int unsigned EN_MAX  = 5;
  localparam int unsigned EN_MIN  = 6;
  localparam int unsigned EN_NOT  = 7;
  localparam int unsigned EN_NAND = 8;
  localparam int unsigned EN_XNOR = 9;
  localparam int unsigned EN_SHL  = 10;
  localparam int unsigned EN_SHRL = 11;
  localparam int unsigned EN_ROL  = 12;
  localparam int unsigned EN_ROR  = 13;
  localparam int unsigned EN_SLT  = 14;

  // Opcode values (low five bits; wider opcodes must be zero above bit 4)
  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_MUL   = 5'd3;
  localparam logic [4:0] OP_DIV   = 5'd4;
  localparam logic [4:0] OP_MOD   = 5'd5;
  localparam logic [4:0] OP_MAX   = 5'd6;
  localparam logic [4:0] OP_MIN   = 5'd7;
  localparam logic [4:0] OP_NOT   = 5'd8;
  localparam logic [4:0] OP_NAND  = 5'd9;
  localparam logic [4:0] OP_XNOR  = 5'd10;
  localparam logic [4:0] OP_SHL   = 5'd11;
  localparam logic [4:0] OP_SHRL  = 5'd12;
  localparam logic [4:0] OP_ROL   = 5'd13;
  localparam logic [4:0] OP_ROR   = 5'd14;
  localparam logic [4:0] OP_SLT   = 5'd15;
  localparam logic [4:0] OP_ADDI  = 5'd18;
  localparam logic [4:0] OP_SUBI  = 5'd19;
  localparam logic [4:0] OP_MULI  = 5'd20;
  localparam logic [4:0] OP_DIVI  = 5'd21;
  localparam logic [4:0] OP_NANDI = 5'd22;
  localparam logic [4:0] OP_XNORI = 5'd23;

  function automatic en_t onehot(input int unsigned idx);
    return en_t'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_opdecode.sv
// Combinational opcode decoder. Immediate aliases (18..23) decode only when
// ALU_SEQ_IMM_EN is defined; otherwise they are illegal and imm stays 0.
module alu_opdecode
  import alu_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0] i_opcode,
  output en_t            o_en_c,
  output logic           o_imm_c,
  output logic           o_multicycle_c,
  output logic           o_lat_sel_c,
  output logic           o_nop_c,
  output logic           o_illegal_c
);

  // Full-width compare so any set bit above bit 4 falls to illegal
  always_comb begin
    o_en_c      = '0;
    o_imm_c     = 1'b0;
    o_nop_c     = 1'b0;
    o_illegal_c = 1'b0;
    case (i_opcode)
      OPW'(OP_NOP):  o_nop_c = 1'b1;
      OPW'(OP_ADD):  o_en_c  = onehot(EN_ADD);
      OPW'(OP_SUB):  o_en_c  = onehot(EN_SUB);
      OPW'(OP_MUL):  o_en_c  = onehot(EN_MUL);
      OPW'(OP_DIV):  o_en_c  = onehot(EN_DIV);
      OPW'(OP_MOD):  o_en_c  = onehot(EN_MOD);
      OPW'(OP_MAX):  o_en_c  = onehot(EN_MAX);
      OPW'(OP_MIN):  o_en_c  = onehot(EN_MIN);
      OPW'(OP_NOT):  o_en_c  = onehot(EN_NOT);
      OPW'(OP_NAND): o_en_c  = onehot(EN_NAND);
      OPW'(OP_XNOR): o_en_c  = onehot(EN_XNOR);
      OPW'(OP_SHL):  o_en_c  = onehot(EN_SHL);
      OPW'(OP_SHRL): o_en_c  = onehot(EN_SHRL);
      OPW'(OP_ROL):  o_en_c  = onehot(EN_ROL);
      OPW'(OP_ROR):  o_en_c  = onehot(EN_ROR);
      OPW'(OP_SLT):  o_en_c  = onehot(EN_SLT);
`ifdef ALU_SEQ_IMM_EN
      OPW'(OP_ADDI):  begin o_en_c = onehot(EN_ADD);  o_imm_c = 1'b1; end
      OPW'(OP_SUBI):  begin o_en_c = onehot(EN_SUB);  o_imm_c = 1'b1; end
      OPW'(OP_MULI):  begin o_en_c = onehot(EN_MUL);  o_imm_c = 1'b1; end
      OPW'(OP_DIVI):  begin o_en_c = onehot(EN_DIV);  o_imm_c = 1'b1; end
      OPW'(OP_NANDI): begin o_en_c = onehot(EN_NAND); o_imm_c = 1'b1; end
      OPW'(OP_XNORI): begin o_en_c = onehot(EN_XNOR); o_imm_c = 1'b1; end
`endif
      default: o_illegal_c = 1'b1;
    endcase
  end

  // MUL uses MUL_LAT (lat_sel=0); DIV and MOD share DIV_LAT (lat_sel=1)
  assign o_multicycle_c = o_en_c[EN_MUL] | o_en_c[EN_DIV] | o_en_c[EN_MOD];
  assign o_lat_sel_c    = o_en_c[EN_DIV] | o_en_c[EN_MOD];

endmodule

// File: rtl/alu_sequencer.sv
// ALU operation sequencer: accepts one opcode at a time, drives a one-hot
// unit enable for one cycle or MUL_LAT/DIV_LAT cycles. Option: ALU_SEQ_IMM_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned OPW     = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [OPW-1:0] opcode,
  input  logic           flush,
  output logic           in_ready,
  output logic [14:0]    en,
  output logic           imm,
  output logic           busy,
  output logic           done,
  output logic           illegal
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  en_t              r_en;
  logic             r_imm;
  logic             r_done;
  logic             r_illegal;

  en_t  w_en;
  logic w_imm;
  logic w_multicycle;
  logic w_lat_sel;
  logic w_nop;
  logic w_illegal;

  alu_opdecode #(.OPW(OPW)) u_dec (
    .i_opcode       (opcode),
    .o_en_c         (w_en),
    .o_imm_c        (w_imm),
    .o_multicycle_c (w_multicycle),
    .o_lat_sel_c    (w_lat_sel),
    .o_nop_c        (w_nop),
    .o_illegal_c    (w_illegal)
  );

  // Sequencer FSM; done is raised one edge early so it lands on the last en cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_en      <= '0;
      r_imm     <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      if (flush) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_en    <= '0;
        r_imm   <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (in_valid) begin
              if (w_illegal) begin
                r_illegal <= 1'b1;
              end else if (w_nop) begin
                r_done <= 1'b1;
              end else if (w_multicycle) begin
                r_state <= ST_WAIT;
                r_en    <= w_en;
                r_imm   <= w_imm;
                r_cnt   <= w_lat_sel ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
              end else begin
                r_state <= ST_EXEC;
                r_en    <= w_en;
                r_imm   <= w_imm;
                r_done  <= 1'b1;
              end
            end
          end
          ST_EXEC: begin
            r_state <= ST_IDLE;
            r_en    <= '0;
            r_imm   <= 1'b0;
          end
          ST_WAIT: begin
            if (r_cnt == '0) begin
              r_state <= ST_IDLE;
              r_en    <= '0;
              r_imm   <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
              if (r_cnt == CNT_W'(1)) r_done <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_en    <= '0;
            r_imm   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign en       = r_en;
  assign imm      = r_imm;
  assign done     = r_done;
  assign illegal  = r_illegal;

endmodule
